// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory.
// The fault check is only used when DMEM_FAULT_EN is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned LANES    = 4;

  localparam logic [LANES-1:0] MASK_BYTE = 4'b0001;
  localparam logic [LANES-1:0] MASK_HALF = 4'b0011;
  localparam logic [LANES-1:0] MASK_WORD = 4'b1111;

  // Misaligned access, reserved size or out-of-range index all fault.
  function automatic logic dmem_fault(input mem_size_e size,
                                      input logic [OFFSET_W-1:0] off,
                                      input logic idx_oob);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis | idx_oob;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting: store mask/replication and load select/extend.
// Half accesses use only offset[1], so they are naturally aligned down.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  mem_size_e             i_size,
  input  logic [OFFSET_W-1:0]   i_offset,
  input  logic                  i_unsigned,
  input  logic [31:0]           i_wdata,
  input  logic [31:0]           i_rword,
  output logic [LANES-1:0]      o_mask,
  output logic [31:0]           o_wdata,
  output logic [31:0]           o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    w_byte = 8'h00;
    case (i_offset)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_offset[1] ? i_rword[31:16] : i_rword[15:0];
  end

  // Size decode; the reserved size behaves as a word access.
  always_comb begin
    o_mask  = MASK_WORD;
    o_wdata = i_wdata;
    o_rdata = i_rword;
    case (i_size)
      SZ_BYTE: begin
        o_mask  = MASK_BYTE << i_offset;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_mask  = i_offset[1] ? (MASK_HALF << 2'd2) : MASK_HALF;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      default: begin
        o_mask  = MASK_WORD;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory with a single registered valid/ready response slot.
// Define DMEM_FAULT_EN to report misaligned, out-of-range and reserved-size requests.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WIDX_W = ADDR_W - OFFSET_W;

  logic [31:0]         r_mem [DEPTH];
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;

  mem_size_e           w_size;
  logic [WIDX_W-1:0]   w_widx;
  logic [IDX_W-1:0]    w_idx;
  logic [OFFSET_W-1:0] w_off;
  logic                w_oob;
  logic                w_fault;
  logic                w_accept;
  logic                w_wr_en;
  logic [LANES-1:0]    w_mask;
  logic [31:0]         w_wrep;
  logic [31:0]         w_rdata_fmt;

  assign w_size = mem_size_e'(req_size);
  assign w_widx = req_addr[ADDR_W-1:OFFSET_W];
  assign w_idx  = w_widx[IDX_W-1:0];
  assign w_off  = req_addr[OFFSET_W-1:0];
  assign w_oob  = (w_widx > WIDX_W'(DEPTH - 1));

`ifdef DMEM_FAULT_EN
  assign w_fault = dmem_fault(w_size, w_off, w_oob);
`else
  logic w_unused;
  assign w_unused = w_oob;
  assign w_fault  = 1'b0;
`endif

  // Gating with rst_n keeps a store coinciding with reset from landing.
  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready && rst_n;
  assign w_wr_en   = w_accept && req_we && !w_fault;

  dmem_lane_fmt u_fmt (
    .i_size     (w_size),
    .i_offset   (w_off),
    .i_unsigned (req_unsigned),
    .i_wdata    (req_wdata),
    .i_rword    (r_mem[w_idx]),
    .o_mask     (w_mask),
    .o_wdata    (w_wrep),
    .o_rdata    (w_rdata_fmt)
  );

  // Byte-enabled array write at the acceptance edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_mask[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
        end
      end
    end
  end

  // Response slot: overwritten on acceptance, cleared once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_fault;
      r_rsp_rdata <= (req_we || w_fault) ? 32'h0000_0000 : w_rdata_fmt;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
